// File: rtl/activation_pipe_pkg.sv
// Shared definitions for the activation pipeline: mode encodings,
// accumulator width derivation and output saturation limits.
package activation_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_RELU   = 2'b00,
    MODE_LEAKY  = 2'b01,
    MODE_LINEAR = 2'b10,
    MODE_RSVD   = 2'b11
  } act_mode_e;

  // Accumulator width: full product width plus guard bits.
  function automatic int calc_in_w(input int data_w, input int ext_w);
    return 2 * data_w + ext_w;
  endfunction

  // Largest representable signed output value for a data_w-bit lane.
  function automatic longint sat_max(input int data_w);
    return (longint'(1) <<< (data_w - 1)) - 1;
  endfunction

  // Smallest representable signed output value for a data_w-bit lane.
  function automatic longint sat_min(input int data_w);
    return -(longint'(1) <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/act_lane.sv
// Single-lane activation datapath: mode apply, round and rescale in
// stage 1, saturate and register in stage 2. Load enables come from the
// shared handshake control in activation_pipe.
module act_lane
  import activation_pipe_pkg::*;
#(
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4,
  parameter int IntWidthExtend = 10,
  parameter int LEAK_SHIFT     = 3,
  localparam int IN_W = calc_in_w(dataWidth, IntWidthExtend)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s1_load,
  input  logic                 s2_load,
  input  logic                 sat_clr,
  input  logic [IN_W-1:0]      lane_in,
  input  logic [1:0]           mode,
  output logic [dataWidth-1:0] lane_out,
  output logic                 sat_flag
);

  localparam int SHIFT = dataWidth - weightIntWidth;
  localparam logic signed [IN_W:0] ROUND_BIT = (IN_W+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'(sat_max(dataWidth));
  localparam logic signed [IN_W:0] SAT_LO = (IN_W+1)'(sat_min(dataWidth));
  localparam logic [dataWidth-1:0] OUT_HI = dataWidth'(sat_max(dataWidth));
  localparam logic [dataWidth-1:0] OUT_LO = dataWidth'(sat_min(dataWidth));

  logic signed [IN_W-1:0]  x;
  logic signed [IN_W-1:0]  act;
  logic signed [IN_W:0]    rounded;
  logic signed [IN_W:0]    scaled;
  logic signed [IN_W:0]    s1_scaled;
  logic [dataWidth-1:0]    sat_val;
  logic                    sat_hit;

  // Stage 1 combinational: apply the activation, then round half up and rescale one bit wider than the input so the add cannot wrap.
  always_comb begin
    x   = $signed(lane_in);
    act = x;
    case (mode)
      MODE_LEAKY:  act = x[IN_W-1] ? (x >>> LEAK_SHIFT) : x;
      MODE_LINEAR: act = x;
      default:     act = x[IN_W-1] ? '0 : x;  // ReLU and the reserved code
    endcase
    rounded = $signed({act[IN_W-1], act}) + ROUND_BIT;
    scaled  = rounded >>> SHIFT;
  end

  // Stage 1 register: holds the full-range rescaled value so stage 2 can detect overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      s1_scaled <= '0;
    else if (s1_load)
      s1_scaled <= scaled;
  end

  // Stage 2 combinational: clamp to the signed output range and flag any clamp.
  always_comb begin
    sat_hit = 1'b0;
    sat_val = s1_scaled[dataWidth-1:0];
    if (s1_scaled > SAT_HI) begin
      sat_val = OUT_HI;
      sat_hit = 1'b1;
    end else if (s1_scaled < SAT_LO) begin
      sat_val = OUT_LO;
      sat_hit = 1'b1;
    end
  end

  // Stage 2 register and sticky saturation flag; a new saturation beats a concurrent clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_out <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (s2_load)
        lane_out <= sat_val;
      sat_flag <= (s2_load && sat_hit) || (sat_flag && !sat_clr);
    end
  end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage multi-lane activation pipeline with valid/ready handshake.
// The handshake control is shared; each lane is an act_lane instance.
module activation_pipe
  import activation_pipe_pkg::*;
#(
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4,
  parameter int IntWidthExtend = 10,
  parameter int NUM_CH         = 8,
  parameter int LEAK_SHIFT     = 3,
  localparam int IN_W = calc_in_w(dataWidth, IntWidthExtend)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_CH*IN_W-1:0]      in_data,
  input  logic [1:0]                  in_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CH*dataWidth-1:0] out_data,
  output logic [NUM_CH-1:0]           sat_flags,
  input  logic                        sat_clr
);

  logic s1_valid;
  logic s2_valid;
  logic s2_adv;
  logic s1_load;
  logic s2_load;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid && s2_adv;
  assign out_valid = s2_valid;

  // Stage occupancy: each stage refills whenever it is empty or its contents move on.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready)
        s1_valid <= in_valid;
      if (s2_adv)
        s2_valid <= s1_valid;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    act_lane #(
      .dataWidth      (dataWidth),
      .weightIntWidth (weightIntWidth),
      .IntWidthExtend (IntWidthExtend),
      .LEAK_SHIFT     (LEAK_SHIFT)
    ) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .s1_load  (s1_load),
      .s2_load  (s2_load),
      .sat_clr  (sat_clr),
      .lane_in  (in_data[i*IN_W +: IN_W]),
      .mode     (in_mode),
      .lane_out (out_data[i*dataWidth +: dataWidth]),
      .sat_flag (sat_flags[i])
    );
  end

endmodule

// File: tb/tb_activation_pipe.sv
// Directed testbench for activation_pipe: table-driven single beats plus
// hand-written backpressure, reset and sticky-flag sequences.
module tb_activation_pipe;
  import activation_pipe_pkg::*;

  localparam int DW     = 16;
  localparam int NUM_CH = 8;
  localparam int IN_W   = 42;

  logic                   clk;
  logic                   rstn;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_CH*IN_W-1:0] in_data;
  logic [1:0]             in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_CH*DW-1:0]   out_data;
  logic [NUM_CH-1:0]      sat_flags;
  logic                   sat_clr;

  int checks = 0;
  int errors = 0;

  activation_pipe #(
    .dataWidth(DW), .weightIntWidth(4), .IntWidthExtend(10),
    .NUM_CH(NUM_CH), .LEAK_SHIFT(3)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_flags(sat_flags), .sat_clr(sat_clr)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    string             name;
    logic [1:0]        mode;
    logic [IN_W-1:0]   l0;
    logic [IN_W-1:0]   l1;
    logic [DW-1:0]     e0;
    logic [DW-1:0]     e1;
    logic [NUM_CH-1:0] esat;
  } vec_t;

  vec_t vecs[10];
  logic [NUM_CH*DW-1:0] expData;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one beat, verify it appears exactly two cycles later; in_mode is scrambled while the beat is in flight.
  task automatic applyStimulus(input logic [1:0] mode, input logic [IN_W-1:0] l0, input logic [IN_W-1:0] l1);
    @(negedge clk);
    in_data = '0;
    in_data[0 +: IN_W]    = l0;
    in_data[IN_W +: IN_W] = l1;
    in_mode   = mode;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("latency_cycle1", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_mode  = ~mode;
    in_data  = '1;
    @(posedge clk);
    #1;
    checkOutput("latency_cycle2", out_valid, 1);
  endtask

  task automatic clearFlags();
    @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
  endtask

  function automatic logic [NUM_CH*IN_W-1:0] beatData(input int k);
    logic [NUM_CH*IN_W-1:0] d;
    logic [IN_W-1:0] v;
    d = '0;
    v = IN_W'(k + 1) << 12;
    d[0 +: IN_W]    = v;
    d[IN_W +: IN_W] = -v;
    return d;
  endfunction

  function automatic logic [NUM_CH*DW-1:0] beatExp(input int k);
    logic [NUM_CH*DW-1:0] e;
    e = '0;
    e[0 +: DW]  = DW'(k + 1);
    e[DW +: DW] = DW'(-(k + 1));
    return e;
  endfunction

  initial begin
    int sent;
    int rcv;
    int c;
    logic accIn;
    logic accOut;

    vecs[0] = '{"relu_basic",    MODE_RELU,   42'sd16777216,      -42'sd5,             16'h1000, 16'h0000, 8'h00};
    vecs[1] = '{"leaky_neg",     MODE_LEAKY,  -42'sd134217728,    42'sd16777216,       16'hF000, 16'h1000, 8'h00};
    vecs[2] = '{"linear_sat",    MODE_LINEAR, 42'sd1099511627776, -42'sd1099511627776, 16'h7FFF, 16'h8000, 8'h03};
    vecs[3] = '{"round_half",    MODE_LINEAR, 42'h0000_1000_800,  42'h0000_7FFF_800,   16'h1001, 16'h7FFF, 8'h02};
    vecs[4] = '{"reserved_relu", MODE_RSVD,   -42'sd16777216,     42'sd16777216,       16'h0000, 16'h1000, 8'h00};
    vecs[5] = '{"relu_zero",     MODE_RELU,   42'h0,              42'h0000_0000_17FF,  16'h0000, 16'h0001, 8'h00};
    vecs[6] = '{"linear_neg",    MODE_LINEAR, -42'sd16777216,     -42'sd2049,          16'hF000, 16'hFFFF, 8'h00};
    vecs[7] = '{"leaky_min",     MODE_LEAKY,  -42'sd8,            42'h200_0000_0000,   16'h0000, 16'h8000, 8'h02};
    vecs[8] = '{"neg_boundary",  MODE_LINEAR, -42'sd134217728,    -42'sd134219777,     16'h8000, 16'h8000, 8'h02};
    vecs[9] = '{"pos_boundary",  MODE_LINEAR, 42'h0000_7FFF_7FF,  42'h0,               16'h7FFF, 16'h0000, 8'h00};

    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = MODE_RELU;
    out_ready = 1'b1;
    sat_clr   = 1'b0;

    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_sat_flags", sat_flags, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Table-driven single beats.
    for (int i = 0; i < 10; i++) begin
      clearFlags();
      applyStimulus(vecs[i].mode, vecs[i].l0, vecs[i].l1);
      expData = '0;
      expData[0 +: DW]  = vecs[i].e0;
      expData[DW +: DW] = vecs[i].e1;
      checkOutput({vecs[i].name, "_data"}, out_data, expData);
      checkOutput({vecs[i].name, "_sat"}, sat_flags, vecs[i].esat);
    end

    // Backpressure: ten beats, out_ready low during cycles 3..6.
    @(posedge clk);
    sent = 0;
    rcv  = 0;
    c    = 0;
    while (rcv < 10 && c < 40) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 10);
      in_mode   = MODE_LINEAR;
      in_data   = beatData(sent);
      #1;
      checkOutput("bp_in_ready", in_ready, !(c >= 3 && c <= 6));
      checkOutput("bp_out_valid", out_valid, (c >= 2));
      if (out_valid)
        checkOutput("bp_data", out_data, beatExp(rcv));
      accIn  = in_valid && in_ready;
      accOut = out_valid && out_ready;
      @(posedge clk);
      if (accIn)  sent++;
      if (accOut) rcv++;
      c++;
    end
    checkOutput("bp_delivered", 128'(rcv), 10);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset with two beats in flight.
    clearFlags();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = MODE_LINEAR;
    in_data   = '0;
    in_data[3*IN_W +: IN_W] = 42'sd1099511627776;
    @(posedge clk);
    @(negedge clk);
    in_data = '0;
    in_data[0 +: IN_W] = 42'sd16777216;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("rst_pre_valid", out_valid, 1);
    checkOutput("rst_pre_sat", sat_flags, 8'h08);
    checkOutput("rst_pre_data", out_data, 128'h7FFF << 48);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_sat_flags", sat_flags, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rstn      = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_no_ghost", out_valid, 0);
    applyStimulus(MODE_RELU, 42'sd16777216, -42'sd5);
    checkOutput("rst_next_data", out_data, 128'h1000);

    // Clear concurrent with a new saturation: lane0 re-saturates, lane1 clears.
    clearFlags();
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = MODE_LINEAR;
    in_data  = '0;
    in_data[0 +: IN_W]    = 42'sd1099511627776;
    in_data[IN_W +: IN_W] = 42'sd1099511627776;
    @(negedge clk);
    in_data = '0;
    in_data[0 +: IN_W] = 42'sd1099511627776;
    @(negedge clk);
    in_valid = 1'b0;
    sat_clr  = 1'b1;
    #1;
    checkOutput("clr_pre_sat", sat_flags, 8'h03);
    @(posedge clk);
    #1;
    checkOutput("clr_set_wins", sat_flags, 8'h01);
    @(negedge clk);
    sat_clr = 1'b0;
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
